// File: rtl/uart_rx_if.sv
// Serial receive bundle: the line into the receiver plus its byte/status outputs.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data, rx_valid, frame_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling, one-cycle valid / framing-error pulses.
module uart_rx #(
  parameter logic [31:0] CLK_PER_BIT = 32'd10417
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [31:0] HALF_LAST = (CLK_PER_BIT / 32'd2) - 32'd1;
  localparam logic [31:0] BIT_LAST  = CLK_PER_BIT - 32'd1;

  logic        rx_p0;
  logic        rx_s;
  logic        rx_prev;

  state_t      state, state_nxt;
  logic [31:0] clk_cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_q, data_nxt;
  logic        valid_q, valid_nxt;
  logic        ferr_q, ferr_nxt;

  // Stage p0/p1: metastability synchronizer plus edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= bus.rx;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= 32'd0;
      idx     <= 3'd0;
      shift   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // Only a genuine 1->0 transition starts a frame, so a line held low
        // after a break or after reset cannot retrigger.
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = 32'd0;
        end
      end

      START: begin
        if (clk_cnt == HALF_LAST) begin
          cnt_nxt = 32'd0;
          if (!rx_s) begin
            state_nxt = DATA;
            idx_nxt   = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = clk_cnt + 32'd1;
        end
      end

      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt        = 32'd0;
          shift_nxt[idx] = rx_s;
          idx_nxt        = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = clk_cnt + 32'd1;
        end
      end

      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_nxt   = 32'd0;
          state_nxt = IDLE;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = clk_cnt + 32'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 32'd0;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes/errors are queued as frames are
// driven and popped when the receiver pulses rx_valid or frame_err.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_valid;
  int   n_err;
  exp_t sb[$];
  exp_t e_mon;

  uart_rx_if bus();

  uart_rx #(.CLK_PER_BIT(32'd16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`define CHK(tag, obs, expv) \
  n_checks++; \
  assert ((obs) === (expv)) else begin \
    n_fail++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (expv)); \
  end

  // Scoreboard consumer: every output pulse must match the head of the queue
  always @(negedge clk) begin
    if (!rst && (bus.rx_valid || bus.frame_err)) begin
      `CHK("pulse_exclusive", bus.rx_valid & bus.frame_err, 1'b0)
      `CHK("pulse_expected", (sb.size() > 0), 1'b1)
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        `CHK("pulse_kind_err", bus.frame_err, e_mon.is_err)
        `CHK("pulse_rx_data", bus.rx_data, e_mon.data)
      end
      if (bus.rx_valid)  n_valid++;
      if (bus.frame_err) n_err++;
    end
  end

  task automatic push_exp(input logic is_err, input logic [7:0] d);
    exp_t x;
    x.is_err = is_err;
    x.data   = d;
    sb.push_back(x);
  endtask

  // Drives one 8N1 frame; rst_bit >= 0 pulses reset mid-way through that data bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (i == rst_bit) begin
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus.rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int waited;
    n_checks = 0;
    n_fail   = 0;
    n_valid  = 0;
    n_err    = 0;
    rst      = 1'b1;
    bus.rx   = 1'b1;

    repeat (3) @(negedge clk);
    `CHK("reset_rx_data", bus.rx_data, 8'h00)
    `CHK("reset_rx_valid", bus.rx_valid, 1'b0)
    `CHK("reset_frame_err", bus.frame_err, 1'b0)
    `CHK("reset_busy", bus.busy, 1'b0)
    rst = 1'b0;
    idle(4);
    `CHK("post_reset_busy", bus.busy, 1'b0)

    // Single good frame
    push_exp(1'b0, 8'h59);
    send_frame(8'h59, 1'b1, -1);
    idle(2 * CPB);
    `CHK("f59_valid_count", n_valid, 1)
    `CHK("f59_err_count", n_err, 0)
    `CHK("f59_rx_data", bus.rx_data, 8'h59)
    `CHK("f59_busy_after", bus.busy, 1'b0)

    // Short low glitch: false start must be rejected quietly
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    waited = 0;
    while (bus.busy && waited < CPB / 2 + 3) begin
      @(negedge clk);
      waited++;
    end
    `CHK("glitch_busy_low", bus.busy, 1'b0)
    idle(2 * CPB);
    `CHK("glitch_valid_count", n_valid, 1)
    `CHK("glitch_err_count", n_err, 0)

    // Framing error: data must keep the previous byte
    push_exp(1'b1, 8'h59);
    send_frame(8'hA5, 1'b0, -1);
    idle(2 * CPB);
    `CHK("ferr_err_count", n_err, 1)
    `CHK("ferr_valid_count", n_valid, 1)
    `CHK("ferr_rx_data_kept", bus.rx_data, 8'h59)

    // Back-to-back frames with no idle gap
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'hFF);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(2 * CPB);
    `CHK("b2b_valid_count", n_valid, 3)
    `CHK("b2b_rx_data", bus.rx_data, 8'hFF)
    `CHK("b2b_sb_empty", sb.size(), 0)

    // Reset during bit 4 aborts the frame; trailing bits are all high so no retrigger
    send_frame(8'hF0, 1'b1, 4);
    idle(2 * CPB);
    `CHK("abort_valid_count", n_valid, 3)
    `CHK("abort_err_count", n_err, 1)
    `CHK("abort_rx_data_reset", bus.rx_data, 8'h00)
    `CHK("abort_busy", bus.busy, 1'b0)
    push_exp(1'b0, 8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    idle(2 * CPB);
    `CHK("f3c_valid_count", n_valid, 4)
    `CHK("f3c_rx_data", bus.rx_data, 8'h3C)

    // Break: 20 bit times low gives exactly one framing error
    push_exp(1'b1, 8'h3C);
    bus.rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    `CHK("break_err_count_low", n_err, 2)
    `CHK("break_busy_low", bus.busy, 1'b0)
    idle(2 * CPB);
    `CHK("break_err_count", n_err, 2)
    push_exp(1'b0, 8'h81);
    send_frame(8'h81, 1'b1, -1);
    idle(2 * CPB);
    `CHK("f81_valid_count", n_valid, 5)
    `CHK("f81_err_count", n_err, 2)
    `CHK("f81_rx_data", bus.rx_data, 8'h81)
    `CHK("final_sb_empty", sb.size(), 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
